// File: rtl/uart_hex_display_pkg.sv
// Shared constants, glyph table and ASCII helper for the UART hex display.
package uart_hex_display_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UF = 8'h46;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LF = 8'h66;

  typedef enum logic {
    MODE_RAW   = 1'b0,
    MODE_ASCII = 1'b1
  } mode_e;

  // Active-high glyphs ordered {G,F,E,D,C,B,A}; 'b' and 'd' are lowercase.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Returns {valid, nibble}; valid is 0 for any non-hex character.
  function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
    logic [7:0] d;
    if (c >= ASCII_0 && c <= ASCII_9) begin
      d = c - ASCII_0;
      return {1'b1, d[3:0]};
    end
    if (c >= ASCII_UA && c <= ASCII_UF) begin
      d = c - ASCII_UA + 8'd10;
      return {1'b1, d[3:0]};
    end
    if (c >= ASCII_LA && c <= ASCII_LF) begin
      d = c - ASCII_LA + 8'd10;
      return {1'b1, d[3:0]};
    end
    return 5'b0;
  endfunction

endpackage

// File: rtl/uart_hex_display_hex_to_seg7.sv
// Registered single-digit hex to 7-segment decoder with blanking.
module hex_to_seg7
  import uart_hex_display_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] glyph;
  logic [6:0] seg_p2;

  assign glyph = blank ? 7'h00 : SEG_TABLE[digit];

  // stage p2: registered segment drive
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_p2 <= SEG_OFF;
    end else begin
      seg_p2 <= ACTIVE_LOW ? ~glyph : glyph;
    end
  end

  assign seg = seg_p2;

endmodule

// File: rtl/uart_hex_display.sv
// N-digit hex display fed by UART_RX bytes (raw or ASCII entry with CR/BS editing).
// Optional echo to UART_TX is compiled in with UART_HEX_DISPLAY_ECHO_EN.
module uart_hex_display
  import uart_hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst,
  input  logic                            i_RX_DV,
  input  logic [7:0]                      i_RX_Byte,
  input  logic                            i_Mode,
  input  logic                            i_TX_Active,
  output logic                            o_TX_DV,
  output logic [7:0]                      o_TX_Byte,
  output logic                            o_Echo_Ovf,
  output logic [4*NUM_DIGITS-1:0]         o_Value,
  output logic [$clog2(NUM_DIGITS+1)-1:0] o_Count,
  output logic [7*NUM_DIGITS-1:0]         o_Segments
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input int inc);
    int s;
    s = int'(c) + inc;
    if (s > NUM_DIGITS) s = NUM_DIGITS;
    return CW'(s);
  endfunction

  logic [VW-1:0] value_p1, value_nxt, byte_ext, nib_ext;
  logic [CW-1:0] count_p1, count_nxt;
  logic [4:0]    nib;
  logic          echo_acc;

  assign nib = ascii_to_nibble(i_RX_Byte);

  always_comb begin
    value_nxt = value_p1;
    count_nxt = count_p1;
    echo_acc  = 1'b0;
    byte_ext  = '0;
    nib_ext   = '0;
    byte_ext[7:0] = i_RX_Byte;
    nib_ext[3:0]  = nib[3:0];
    if (i_RX_DV) begin
      if (mode_e'(i_Mode) == MODE_RAW) begin
        value_nxt = (value_p1 << 8) | byte_ext;
        count_nxt = sat_inc(count_p1, 2);
      end else if (nib[4]) begin
        value_nxt = (value_p1 << 4) | nib_ext;
        count_nxt = sat_inc(count_p1, 1);
        echo_acc  = 1'b1;
      end else if (i_RX_Byte == ASCII_CR) begin
        value_nxt = '0;
        count_nxt = '0;
        echo_acc  = 1'b1;
      end else if (i_RX_Byte == ASCII_BS) begin
        echo_acc = 1'b1;
        if (count_p1 != '0) begin
          value_nxt = value_p1 >> 4;
          count_nxt = count_p1 - CW'(1);
        end
      end
    end
  end

  // stage p1: digit register and valid-digit count
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      value_p1 <= '0;
      count_p1 <= '0;
    end else begin
      value_p1 <= value_nxt;
      count_p1 <= count_nxt;
    end
  end

  assign o_Value = value_p1;
  assign o_Count = count_p1;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    hex_to_seg7 #(.ACTIVE_LOW(ACTIVE_LOW)) u_seg (
      .clk   (i_Clk),
      .rst   (i_Rst),
      .digit (value_p1[4*k +: 4]),
      .blank (int'(count_p1) <= k),
      .seg   (o_Segments[7*k +: 7])
    );
  end

`ifdef UART_HEX_DISPLAY_ECHO_EN
  logic       buf_full_p1;
  logic [7:0] buf_byte_p1;
  logic       tx_dv_p2;
  logic [7:0] tx_byte_p2;
  logic       ovf_p1;

  // stage p1 -> p2: one-entry echo buffer drained when the transmitter is idle
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      buf_full_p1 <= 1'b0;
      tx_dv_p2    <= 1'b0;
      tx_byte_p2  <= 8'h00;
      ovf_p1      <= 1'b0;
    end else begin
      tx_dv_p2 <= 1'b0;
      if (buf_full_p1 && !i_TX_Active) begin
        tx_dv_p2    <= 1'b1;
        tx_byte_p2  <= buf_byte_p1;
        buf_full_p1 <= 1'b0;
      end
      if (echo_acc) begin
        if (i_RX_Byte == ASCII_CR) ovf_p1 <= 1'b0;
        // A drop sets the flag after any CR clear, so set wins.
        if (buf_full_p1) begin
          ovf_p1 <= 1'b1;
        end else begin
          buf_full_p1 <= 1'b1;
          buf_byte_p1 <= i_RX_Byte;
        end
      end
    end
  end

  assign o_TX_DV    = tx_dv_p2;
  assign o_TX_Byte  = tx_byte_p2;
  assign o_Echo_Ovf = ovf_p1;
`else
  logic unused_echo;
  assign unused_echo = ^{i_TX_Active, echo_acc};
  assign o_TX_DV     = 1'b0;
  assign o_TX_Byte   = 8'h00;
  assign o_Echo_Ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_hex_display.sv
// Scoreboard bench for uart_hex_display with NUM_DIGITS = 4, ACTIVE_LOW = 1.
module tb_uart_hex_display;

  logic        clk = 1'b0;
  logic        rst, rx_dv, mode, tx_active;
  logic [7:0]  rx_byte;
  logic        tx_dv, echo_ovf;
  logic [7:0]  tx_byte;
  logic [15:0] value;
  logic [2:0]  count;
  logic [27:0] segs;

  int checks = 0;
  int errors = 0;
  logic track = 1'b1;
  logic dv_d1 = 1'b0;
  logic dv_d2 = 1'b0;

  logic [15:0] val_q[$];
  int          cnt_q[$];
  logic [27:0] seg_q[$];
  logic [7:0]  tx_q[$];

  localparam logic [6:0] BL = 7'h00, S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F,
                         S4 = 7'h66, S5 = 7'h6D, S6 = 7'h7D, SA = 7'h77, SB = 7'h7C,
                         SD = 7'h5E, SF = 7'h71;
  localparam logic [27:0] OFF = 28'hFFFFFFF;
`ifdef UART_HEX_DISPLAY_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  uart_hex_display #(.NUM_DIGITS(4), .ACTIVE_LOW(1'b1)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .i_Mode      (mode),
    .i_TX_Active (tx_active),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .o_Echo_Ovf  (echo_ovf),
    .o_Value     (value),
    .o_Count     (count),
    .o_Segments  (segs)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] segs4(input logic [6:0] d3, d2, d1, d0);
    return ~{d3, d2, d1, d0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got output with no expectation queued", nm);
  endtask

  // Called aligned to a negedge; returns aligned to a negedge.
  task automatic send(input logic [7:0] b, input logic m, input logic [15:0] ev,
                      input int ec, input logic [27:0] es, input int echo, input int gap);
    val_q.push_back(ev);
    cnt_q.push_back(ec);
    seg_q.push_back(es);
    if (ECHO && echo >= 0) tx_q.push_back(echo[7:0]);
    rx_dv = 1'b1; rx_byte = b; mode = m;
    @(negedge clk);
    rx_dv = 1'b0; mode = ~m;
    repeat (gap) @(negedge clk);
  endtask

  always @(posedge clk) begin
    dv_d1 <= rx_dv && track && !rst;
    dv_d2 <= dv_d1;
  end

  always @(negedge clk) begin
    if (dv_d1) begin
      if (val_q.size() == 0) fail_now("value");
      else begin
        chk("value", 32'(value), 32'(val_q.pop_front()));
        chk("count", 32'(count), 32'(cnt_q.pop_front()));
      end
    end
    if (dv_d2) begin
      if (seg_q.size() == 0) fail_now("segments");
      else chk("segments", 32'(segs), 32'(seg_q.pop_front()));
    end
    if (tx_dv) begin
      if (tx_q.size() == 0) fail_now("tx_dv");
      else chk("tx_byte", 32'(tx_byte), 32'(tx_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; mode = 1'b0; tx_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst value", 32'(value), 0);
    chk("rst count", 32'(count), 0);
    chk("rst segs", 32'(segs), 32'(OFF));
    chk("rst tx_dv", 32'(tx_dv), 0);
    chk("rst tx_byte", 32'(tx_byte), 0);
    chk("rst ovf", 32'(echo_ovf), 0);
    rst = 1'b0;
    @(negedge clk);

    // Raw mode, then back-to-back raw bytes with saturation
    send(8'hA5, 1'b0, 16'h00A5, 2, segs4(BL, BL, SA, S5), -1, 3);
    send(8'h12, 1'b0, 16'hA512, 4, segs4(SA, S5, S1, S2), -1, 0);
    send(8'h34, 1'b0, 16'h1234, 4, segs4(S1, S2, S3, S4), -1, 0);
    send(8'h56, 1'b0, 16'h3456, 4, segs4(S3, S4, S5, S6), -1, 3);

    // ASCII entry and editing
    send(8'h0D, 1'b1, 16'h0000, 0, OFF, 'h0D, 3);
    send(8'h31, 1'b1, 16'h0001, 1, segs4(BL, BL, BL, S1), 'h31, 3);
    send(8'h62, 1'b1, 16'h001B, 2, segs4(BL, BL, S1, SB), 'h62, 3);
    send(8'h46, 1'b1, 16'h01BF, 3, segs4(BL, S1, SB, SF), 'h46, 3);
    send(8'h08, 1'b1, 16'h001B, 2, segs4(BL, BL, S1, SB), 'h08, 3);
    send(8'h47, 1'b1, 16'h001B, 2, segs4(BL, BL, S1, SB), -1, 3);
    send(8'h0D, 1'b1, 16'h0000, 0, OFF, 'h0D, 3);
    send(8'h08, 1'b1, 16'h0000, 0, OFF, 'h08, 3);

    // ASCII overflow drops the oldest digit
    send(8'h31, 1'b1, 16'h0001, 1, segs4(BL, BL, BL, S1), 'h31, 3);
    send(8'h32, 1'b1, 16'h0012, 2, segs4(BL, BL, S1, S2), 'h32, 3);
    send(8'h33, 1'b1, 16'h0123, 3, segs4(BL, S1, S2, S3), 'h33, 3);
    send(8'h34, 1'b1, 16'h1234, 4, segs4(S1, S2, S3, S4), 'h34, 3);
    send(8'h35, 1'b1, 16'h2345, 4, segs4(S2, S3, S4, S5), 'h35, 3);
    send(8'h0D, 1'b1, 16'h0000, 0, OFF, 'h0D, 3);

    // Lowercase entry, then a CR code in raw mode is plain data
    send(8'h64, 1'b1, 16'h000D, 1, segs4(BL, BL, BL, SD), 'h64, 3);
    send(8'h61, 1'b1, 16'h00DA, 2, segs4(BL, BL, SD, SA), 'h61, 3);
    send(8'h0D, 1'b0, 16'hDA0D, 4, segs4(SD, SA, S0, SD), -1, 3);
    send(8'h0D, 1'b1, 16'h0000, 0, OFF, 'h0D, 3);

    // Echo held off by a busy transmitter
    tx_active = 1'b1;
    send(8'h31, 1'b1, 16'h0001, 1, segs4(BL, BL, BL, S1), 'h31, 3);
    send(8'h32, 1'b1, 16'h0012, 2, segs4(BL, BL, S1, S2), -1, 3);
    chk("ovf after drop", 32'(echo_ovf), 32'(ECHO));
    chk("echo pending", tx_q.size(), 32'(ECHO));
    tx_active = 1'b0;
    repeat (4) @(negedge clk);
    chk("echo drained", tx_q.size(), 0);
    chk("ovf sticky", 32'(echo_ovf), 32'(ECHO));
    send(8'h0D, 1'b1, 16'h0000, 0, OFF, 'h0D, 4);
    chk("ovf cleared by CR", 32'(echo_ovf), 0);

    // Reset one cycle after an accepted byte
    track = 1'b0;
    rx_dv = 1'b1; rx_byte = 8'h37; mode = 1'b1;
    @(negedge clk);
    rx_dv = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid-rst value", 32'(value), 0);
    chk("mid-rst count", 32'(count), 0);
    chk("mid-rst segs", 32'(segs), 32'(OFF));
    chk("mid-rst tx_byte", 32'(tx_byte), 0);
    chk("mid-rst ovf", 32'(echo_ovf), 0);
    repeat (8) @(negedge clk);
    chk("post-rst value", 32'(value), 0);
    track = 1'b1;

    repeat (4) @(negedge clk);
    chk("tx queue empty", tx_q.size(), 0);
    chk("state queue empty", val_q.size(), 0);
    chk("seg queue empty", seg_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
